// File: rtl/spi_rom_read_arbiter_if.sv
// Request, read-data and SPI pin bundle shared by spi_rom_read_arbiter and its requesters.
interface spi_rom_read_arbiter_if #(
  parameter int unsigned LEN_W = 8
);
  logic             req0_valid;
  logic [23:0]      req0_addr;
  logic [LEN_W-1:0] req0_len;
  logic             req0_ready;
  logic             req1_valid;
  logic [23:0]      req1_addr;
  logic [LEN_W-1:0] req1_len;
  logic             req1_ready;
  logic             abort;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_id;
  logic             rd_last;
  logic             busy;
  logic             spi_cs;
  logic             spi_sclk;
  logic             spi_mosi;
  logic             spi_miso;

  modport slave (
    input  req0_valid, req0_addr, req0_len,
    output req0_ready,
    input  req1_valid, req1_addr, req1_len,
    output req1_ready,
    input  abort,
    output rd_data, rd_valid, rd_id, rd_last, busy,
    output spi_cs, spi_sclk, spi_mosi,
    input  spi_miso
  );

  modport master (
    output req0_valid, req0_addr, req0_len,
    input  req0_ready,
    output req1_valid, req1_addr, req1_len,
    input  req1_ready,
    output abort,
    input  rd_data, rd_valid, rd_id, rd_last, busy,
    input  spi_cs, spi_sclk, spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_rom_read_arbiter.sv
// Two-port arbiter + SPI READ sequencer for a shared flash ROM (port 0 has priority).
// Define FAST_READ_EN to use command 0x0B with an 8-bit dummy phase after the address.
module spi_rom_read_arbiter #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned CS_GAP = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  spi_rom_read_arbiter_if.slave        bus
);

`ifdef FAST_READ_EN
  localparam logic [7:0]  RD_CMD = 8'h0B;
  localparam int unsigned TX_W   = 40;
`else
  localparam logic [7:0]  RD_CMD = 8'h03;
  localparam int unsigned TX_W   = 32;
`endif
  localparam int unsigned TXR_W  = TX_W - 1;
  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned GAP_W  = $clog2(CS_GAP + 1);
  localparam int unsigned BIT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_e;

`ifdef FAST_READ_EN
  localparam state_e ADDR_NEXT = S_DUMMY;
`else
  localparam state_e ADDR_NEXT = S_DATA;
`endif

  state_e             state_q, state_d;
  logic [TXR_W-1:0]   tx_q, tx_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               id_q, id_d;
  logic [6:0]         rx_q, rx_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_id_q, rd_id_d;
  logic               rd_last_q, rd_last_d;
  logic               busy_q, busy_d;

  logic               grant0_c;
  logic               grant1_c;
  logic [23:0]        req_addr_c;
  logic [LEN_W-1:0]   req_len_c;
  logic [BIT_W-1:0]   last_bit_c;
  logic               last_byte_c;

  // Arbitration is only open in IDLE; port 0 masks port 1.
  assign grant0_c    = (state_q == S_IDLE) & bus.req0_valid;
  assign grant1_c    = (state_q == S_IDLE) & bus.req1_valid & ~bus.req0_valid;
  assign req_addr_c  = grant0_c ? bus.req0_addr : bus.req1_addr;
  assign req_len_c   = grant0_c ? bus.req0_len  : bus.req1_len;
  assign last_bit_c  = (state_q == S_ADDR) ? BIT_W'(23) : BIT_W'(7);
  assign last_byte_c = ((byte_cnt_q + CNT_W'(1)) == len_q);

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_id      = rd_id_q;
  assign bus.rd_last    = rd_last_q;
  assign bus.busy       = busy_q;
  assign bus.spi_cs     = cs_q;
  assign bus.spi_sclk   = sclk_q;
  assign bus.spi_mosi   = mosi_q;

  // Next-state / output logic: sclk_q low = low phase, high = high phase of the current bit.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    id_d       = id_q;
    rx_d       = rx_q;
    gap_cnt_d  = gap_cnt_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant0_c || grant1_c) begin
          state_d    = S_CMD;
          cs_d       = 1'b1;
          sclk_d     = 1'b0;
          mosi_d     = RD_CMD[7];
          tx_d       = TXR_W'({RD_CMD[6:0], req_addr_c}) << (TX_W - 32);
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          gap_cnt_d  = '0;
          id_d       = grant1_c;
          len_d      = (req_len_c == '0) ? {1'b1, LEN_W'(0)} : {1'b0, req_len_c};
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (bus.abort) begin
          state_d   = S_GAP;
          cs_d      = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = 1'b0;
          gap_cnt_d = '0;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          if (state_q == S_DATA) begin
            rx_d = {rx_q[5:0], bus.spi_miso};
            if (bit_cnt_q == BIT_W'(7)) begin
              rd_valid_d = 1'b1;
              rd_data_d  = {rx_q, bus.spi_miso};
              rd_id_d    = id_q;
              rd_last_d  = last_byte_c;
            end
          end
        end else begin
          // Falling edge: advance the bit; MOSI only ever changes here.
          sclk_d    = 1'b0;
          mosi_d    = tx_q[TXR_W-1];
          tx_d      = tx_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == last_bit_c) begin
            bit_cnt_d = '0;
            if (state_q == S_CMD) begin
              state_d = S_ADDR;
            end else if (state_q == S_ADDR) begin
              state_d = ADDR_NEXT;
            end else if (state_q == S_DUMMY) begin
              state_d = S_DATA;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
              if (last_byte_c) begin
                state_d   = S_GAP;
                cs_d      = 1'b0;
                mosi_d    = 1'b0;
                gap_cnt_d = '0;
              end
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      id_q       <= 1'b0;
      rx_q       <= '0;
      gap_cnt_q  <= '0;
      cs_q       <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      id_q       <= id_d;
      rx_q       <= rx_d;
      gap_cnt_q  <= gap_cnt_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_rom_read_arbiter.sv
// Bench for spi_rom_read_arbiter: behavioural SPI ROM, directed cases and random transactions.
module tb_spi_rom_read_arbiter;

  localparam int CS_GAP = 4;
`ifdef FAST_READ_EN
  localparam int XTRA = 16;
  localparam int HDR  = 40;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int XTRA = 0;
  localparam int HDR  = 32;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       id;
    logic       last;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;

  spi_rom_read_arbiter_if #(.LEN_W(8)) bus ();

  spi_rom_read_arbiter #(.LEN_W(8), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ROM contents: two fixed bytes at 0x120, a hash elsewhere.
  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    if (a == 24'h000120) return 8'hA5;
    if (a == 24'h000121) return 8'h3C;
    return a[7:0] ^ (a[15:8] * 8'd3) ^ a[23:16] ^ 8'h96;
  endfunction

  // Behavioural SPI ROM: count sclk rises while selected, shift in header, serve data MSB first.
  int          nbits;
  logic [31:0] hdr;
  logic [7:0]  dummy;

  function automatic logic miso_fn(input int n, input logic [31:0] h);
    logic [7:0] b;
    int j;
    if (n < HDR) return 1'(n >= 32);
    j = n - HDR;
    b = rom_byte(h[23:0] + 24'(j / 8));
    return b[3'(7 - (j % 8))];
  endfunction

  assign bus.spi_miso = miso_fn(nbits, hdr);

  always @(negedge bus.spi_cs) begin
    nbits = 0;
    dummy = 8'hFF;
  end

  always @(posedge bus.spi_sclk) begin
    if (bus.spi_cs) begin
      if (nbits < 32) hdr = {hdr[30:0], bus.spi_mosi};
      else if (nbits < 40) dummy = {dummy[6:0], bus.spi_mosi};
      nbits = nbits + 1;
    end
  end

  // Observation of read strobes and chip-select edges.
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic cs_prev;
  int   cs_rise;
  int   cs_fall;
  int   sclk_viol;

  always @(negedge clk) begin
    if (bus.rd_valid) obs_q.push_back('{c: cyc, d: bus.rd_data, id: bus.rd_id, last: bus.rd_last});
    if (bus.spi_cs && !cs_prev) cs_rise = cyc;
    if (!bus.spi_cs && cs_prev) cs_fall = cyc;
    if (!bus.spi_cs && bus.spi_sclk) sclk_viol++;
    cs_prev = bus.spi_cs;
  end

  task automatic accept(input bit port, input logic [23:0] a, input logic [7:0] l, output int t);
    bit got;
    got = 0;
    t = 0;
    @(negedge clk);
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_len = l;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_len = l;
    end
    for (int i = 0; i < 9000 && !got; i++) begin
      #1;
      if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        got = 1;
        t = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_timeout", int'(got), 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Reference: expected strobes and pin timing from the acceptance cycle t.
  task automatic finish_txn(input int t, input bit id, input logic [23:0] a, input int l, input int off);
    bit   aborted;
    bit   done;
    int   exp_fall;
    int   idle_c;
    ev_t  e;
    ev_t  o;
    aborted  = (off >= 1) && (off <= 64 + XTRA + 16 * l);
    exp_fall = aborted ? t + off + 1 : t + 65 + XTRA + 16 * l;
    for (int k = 0; k < l; k++) begin
      if (aborted && (80 + XTRA + 16 * k) > off) break;
      exp_q.push_back('{c: t + 80 + XTRA + 16 * k, d: rom_byte(a + 24'(k)), id: id, last: (k == l - 1)});
    end
    if (off > 0) begin
      do @(negedge clk); while (cyc < t + off);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
    end
    done = 0;
    for (int i = 0; i < 8000 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    #1;
    idle_c = cyc;
    chk("idle_timeout", int'(done), 1);
    chk("cs_rise", cs_rise, t + 1);
    chk("cs_fall", cs_fall, exp_fall);
    chk("cs_high_cycles", cs_fall - cs_rise, exp_fall - t - 1);
    chk("idle_cycle", idle_c, exp_fall + CS_GAP);
    if (!aborted) begin
      chk("mosi_header", int'(hdr), int'({EXP_CMD, a}));
`ifdef FAST_READ_EN
      chk("mosi_dummy", int'(dummy), 0);
`endif
    end
    chk("rd_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("rd_cycle", o.c, e.c);
      chk("rd_data", int'(o.d), int'(e.d));
      chk("rd_id", int'(o.id), int'(e.id));
      chk("rd_last", int'(o.last), int'(e.last));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int          t;
    int          t1;
    bit          port;
    logic [23:0] a;
    int          l;
    int          off;

    clk = 1'b0; reset = 1'b1; cyc = 0; n_checks = 0; n_err = 0;
    cs_prev = 1'b0; cs_rise = -1; cs_fall = -1; sclk_viol = 0;
    nbits = 0; hdr = '0; dummy = 8'hFF;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_len = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_len = '0;
    bus.abort = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", int'(bus.spi_cs), 0);
    chk("rst_sclk", int'(bus.spi_sclk), 0);
    chk("rst_mosi", int'(bus.spi_mosi), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_last", int'(bus.rd_last), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Reset in the middle of DATA after two bytes have been delivered to port 1.
    accept(1'b1, 24'h000120, 8'd3, t);
    while (cyc < t + 100 + XTRA) @(negedge clk);
    chk("pre_rst_rd_id", int'(bus.rd_id), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", int'(bus.spi_cs), 0);
    chk("mid_rst_sclk", int'(bus.spi_sclk), 0);
    chk("mid_rst_mosi", int'(bus.spi_mosi), 0);
    chk("mid_rst_rd_valid", int'(bus.rd_valid), 0);
    chk("mid_rst_rd_last", int'(bus.rd_last), 0);
    chk("mid_rst_rd_id", int'(bus.rd_id), 0);
    chk("mid_rst_rd_data", int'(bus.rd_data), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();

    // Known two-byte read.
    accept(1'b0, 24'h000120, 8'd2, t);
    finish_txn(t, 1'b0, 24'h000120, 2, 0);

    // Simultaneous requests: port 0 wins, port 1 follows after the deselect gap.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 24'h0A0B00; bus.req0_len = 8'd2;
    bus.req1_valid = 1'b1; bus.req1_addr = 24'h123456; bus.req1_len = 8'd1;
    #1;
    chk("dual_ready0", int'(bus.req0_ready), 1);
    chk("dual_ready1", int'(bus.req1_ready), 0);
    t = cyc;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("busy_ready1", int'(bus.req1_ready), 0);
    finish_txn(t, 1'b0, 24'h0A0B00, 2, 0);
    chk("dual_ready1_gap", int'(bus.req1_ready), 1);
    t1 = cyc;
    chk("dual_accept_cycle", t1, cs_fall + CS_GAP);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    finish_txn(t1, 1'b1, 24'h123456, 1, 0);

    // len==0 means 256 bytes.
    accept(1'b0, 24'h00F000, 8'd0, t);
    finish_txn(t, 1'b0, 24'h00F000, 256, 0);

    // Abort during the second byte; abort during GAP is ignored.
    accept(1'b0, 24'h004400, 8'd4, t);
    finish_txn(t, 1'b0, 24'h004400, 4, 85 + XTRA);
    accept(1'b1, 24'h004400, 8'd1, t);
    finish_txn(t, 1'b1, 24'h004400, 1, 66 + XTRA + 16);

    // Random traffic, some with an abort anywhere in the active window.
    for (int n = 0; n < 14; n++) begin
      port = 1'($urandom % 2);
      a    = 24'($urandom);
      l    = 1 + int'($urandom % 5);
      off  = 0;
      if (($urandom % 3) == 0) off = int'($urandom_range(1, 64 + XTRA + 16 * l));
      accept(port, a, 8'(l), t);
      finish_txn(t, port, a, l, off);
    end

    chk("sclk_low_while_deselected", sclk_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
